// File: rtl/multi_button_debouncer_pkg.sv
// Shared constants and width helpers for the multi-button debouncer.
// Optional auto-repeat is enabled by MULTI_BUTTON_DEBOUNCER_REPEAT_EN.
package multi_button_debouncer_pkg;

  localparam int TICK_DIV_DEFAULT = 262144;
  localparam int SAMPLES_DEFAULT  = 3;

  function automatic int div_width(input int tick_div);
    return $clog2(tick_div);
  endfunction

  function automatic int rpt_width(input int delay);
    return $clog2(delay + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced button: synchroniser, sample history, hysteresis, pulses.
// Auto-repeat on rise is built only with MULTI_BUTTON_DEBOUNCER_REPEAT_EN.
module debounce_channel
  import multi_button_debouncer_pkg::*;
#(
  parameter int SAMPLES       = SAMPLES_DEFAULT,
  parameter int REPEAT_DELAY  = 50,
  parameter int REPEAT_PERIOD = 10
) (
  input  logic clk,
  input  logic clr,
  input  logic tick,
  input  logic inp,
  output logic outp,
  output logic rise,
  output logic fall
);

  logic               s1;
  logic               s2;
  logic [SAMPLES-1:0] hist;
  logic [SAMPLES-1:0] hist_nx;
  logic               out_nx;
  logic               press;
  logic               drop;
  logic               rpt;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= inp;
      s2 <= s1;
    end
  end

  assign hist_nx = {hist[SAMPLES-2:0], s2};

  // Mixed histories hold the current level.
  always_comb begin
    out_nx = outp;
    if (tick && (&hist_nx))
      out_nx = 1'b1;
    else if (tick && !(|hist_nx))
      out_nx = 1'b0;
  end

  assign press = out_nx & ~outp;
  assign drop  = ~out_nx & outp;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      hist <= '0;
      outp <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      if (tick)
        hist <= hist_nx;
      outp <= out_nx;
      rise <= press | rpt;
      fall <= drop;
    end
  end

`ifdef MULTI_BUTTON_DEBOUNCER_REPEAT_EN
  localparam int RW = rpt_width(REPEAT_DELAY);

  logic [RW-1:0] rcnt;
  logic [RW-1:0] rcnt_inc;

  assign rcnt_inc = rcnt + RW'(1);
  assign rpt = tick & outp & out_nx
             & (rcnt_inc == RW'(REPEAT_DELAY));

  always_ff @(posedge clk or posedge clr) begin
    if (clr)
      rcnt <= '0;
    else if (!out_nx)
      rcnt <= '0;
    else if (tick && outp)
      rcnt <= rpt ? RW'(REPEAT_DELAY - REPEAT_PERIOD)
                  : rcnt_inc;
  end
`else
  logic unused_rpt;
  assign unused_rpt = ^{REPEAT_DELAY[0], REPEAT_PERIOD[0]};
  assign rpt = 1'b0;
`endif

endmodule

// File: rtl/multi_button_debouncer.sv
// N-channel button debouncer with a shared sample-tick divider.
// Optional auto-repeat: define MULTI_BUTTON_DEBOUNCER_REPEAT_EN.
module multi_button_debouncer
  import multi_button_debouncer_pkg::*;
#(
  parameter int CHANNELS      = 4,
  parameter int TICK_DIV      = TICK_DIV_DEFAULT,
  parameter int SAMPLES       = SAMPLES_DEFAULT,
  parameter int REPEAT_DELAY  = 50,
  parameter int REPEAT_PERIOD = 10
) (
  input  logic                clk,
  input  logic                clr,
  input  logic [CHANNELS-1:0] inp,
  output logic [CHANNELS-1:0] outp,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic                tick
);

  localparam int DW = div_width(TICK_DIV);

  logic [DW-1:0] cnt;

  // tick is registered so it is high while cnt == TICK_DIV-1.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= (cnt == DW'(TICK_DIV - 1)) ? '0 : cnt + DW'(1);
      tick <= (cnt == DW'(TICK_DIV - 2));
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    debounce_channel #(
      .SAMPLES      (SAMPLES),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_ch (
      .clk (clk),
      .clr (clr),
      .tick(tick),
      .inp (inp[g]),
      .outp(outp[g]),
      .rise(rise[g]),
      .fall(fall[g])
    );
  end

endmodule

// File: tb/tb_multi_button_debouncer.sv
// Randomised and directed bench for multi_button_debouncer.
// Reference model tracks sample runs per channel, not the RTL shift register.
module tb_multi_button_debouncer;

  localparam int CH = 4;
  localparam int TD = 4;
  localparam int SM = 3;
  localparam int RD = 5;
  localparam int RP = 2;
`ifdef MULTI_BUTTON_DEBOUNCER_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          clr = 1'b1;
  logic [CH-1:0] inp = '0;
  logic [CH-1:0] outp;
  logic [CH-1:0] rise;
  logic [CH-1:0] fall;
  logic          tick;

  int n_chk = 0;
  int n_err = 0;

  multi_button_debouncer #(
    .CHANNELS(CH), .TICK_DIV(TD), .SAMPLES(SM),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .clr(clr), .inp(inp),
    .outp(outp), .rise(rise), .fall(fall), .tick(tick)
  );

  always #5 clk = ~clk;

  // model state
  int            edges;
  logic [CH-1:0] p1, p2;
  logic [CH-1:0] m_out, m_rise, m_fall;
  logic          m_tick;
  int            run_len [CH];
  logic          run_val [CH];
  int            held    [CH];
  int            rise_cnt[CH];
  int            fall_cnt[CH];
  int            tick_cnt;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    edges  = 0;
    p1     = '0;
    p2     = '0;
    m_out  = '0;
    m_rise = '0;
    m_fall = '0;
    m_tick = 1'b0;
    for (int i = 0; i < CH; i++) begin
      run_len[i] = SM;
      run_val[i] = 1'b0;
      held[i]    = 0;
    end
  endtask

  // Level changes once SM consecutive equal samples are seen.
  task automatic model_edge();
    bit            tk;
    logic [CH-1:0] s;
    tk     = ((edges % TD) == TD - 1);
    s      = p2;
    m_rise = '0;
    m_fall = '0;
    if (tk) begin
      for (int i = 0; i < CH; i++) begin
        if (s[i] == run_val[i]) run_len[i]++;
        else begin
          run_val[i] = s[i];
          run_len[i] = 1;
        end
        if (run_len[i] >= SM && run_val[i] != m_out[i]) begin
          m_out[i]  = run_val[i];
          m_rise[i] = run_val[i];
          m_fall[i] = !run_val[i];
          held[i]   = 0;
        end else if (m_out[i]) begin
          held[i]++;
          if (REP && held[i] >= RD && ((held[i] - RD) % RP) == 0)
            m_rise[i] = 1'b1;
        end
      end
    end
    p2 = p1;
    p1 = inp;
    edges++;
    m_tick = ((edges % TD) == TD - 1);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("outp", outp, m_out);
    chk("rise", rise, m_rise);
    chk("fall", fall, m_fall);
    chk("tick", tick, m_tick);
    for (int i = 0; i < CH; i++) begin
      rise_cnt[i] += rise[i];
      fall_cnt[i] += fall[i];
    end
    tick_cnt += tick;
    @(negedge clk);
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic clr_counts();
    for (int i = 0; i < CH; i++) begin
      rise_cnt[i] = 0;
      fall_cnt[i] = 0;
    end
    tick_cnt = 0;
  endtask

  task automatic do_reset();
    clr = 1'b1;
    model_reset();
    #1;
    chk("rst_outp", outp, 0);
    chk("rst_rise", rise, 0);
    chk("rst_fall", fall, 0);
    chk("rst_tick", tick, 0);
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    int first;
    int n;
    int nt;
    int rt[$];
    clr_counts();
    model_reset();
    inp = '1;
    @(negedge clk);
    @(negedge clk);
    do_reset();

    // first tick in the 4th cycle after release
    first = 0;
    for (int k = 1; k <= 12; k++) begin
      if (tick && first == 0) first = k;
      step();
    end
    chk("tick_first", first, 4);
    inp = '0;
    steps(20);

    // clean press and release on channel 0
    clr_counts();
    inp = 4'b0001;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      n++;
      if (rise[0]) break;
    end
    chk("press_seen", rise[0], 1);
    chk("press_lat", (n <= 2 + SM * TD), 1);
    steps(4);
    chk("press_once", rise_cnt[0], 1);
    chk("press_others", outp[3:1], 0);
    inp = 4'b0000;
    for (int k = 0; k < 20; k++) begin
      step();
      if (fall[0]) break;
    end
    chk("rel_seen", fall[0], 1);
    step();
    chk("rel_width", fall[0], 0);
    chk("rel_outp", outp[0], 0);
    steps(8);

    // short glitches on channel 1 in both directions
    clr_counts();
    inp[1] = 1'b1;
    steps(3);
    inp[1] = 1'b0;
    steps(16);
    chk("glitch_hi_outp", outp[1], 0);
    chk("glitch_hi_rise", rise_cnt[1], 0);
    inp[1] = 1'b1;
    steps(20);
    chk("hold_outp", outp[1], 1);
    clr_counts();
    inp[1] = 1'b0;
    steps(3);
    inp[1] = 1'b1;
    steps(16);
    chk("glitch_lo_outp", outp[1], 1);
    chk("glitch_lo_fall", fall_cnt[1], 0);
    inp[1] = 1'b0;
    steps(20);

    // simultaneous press on channels 1 and 3
    inp = 4'b1010;
    for (int k = 0; k < 20; k++) begin
      step();
      if (rise != 0) break;
    end
    chk("simul_rise", rise, 4'b1010);
    inp = 4'b0000;
    steps(20);

    // reset after two good samples on channel 3
    inp[3] = 1'b1;
    for (int k = 0; k < 40; k++) begin
      step();
      if (run_val[3] && run_len[3] == 2) break;
    end
    chk("mid_two_samples", run_len[3], 2);
    do_reset();
    nt = 0;
    n  = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (rise[3]) begin
        n = 1;
        break;
      end
      nt += tick;
    end
    chk("rearm_rise", n, 1);
    chk("rearm_ticks", nt, SM);
    inp[3] = 1'b0;
    steps(20);

    // auto-repeat spacing on channel 2
    if (REP) begin
      clr_counts();
      inp[2] = 1'b1;
      for (int k = 0; k < 60; k++) begin
        step();
        if (rise[2]) rt.push_back(tick_cnt);
      end
      chk("rpt_count", (rt.size() >= 3), 1);
      if (rt.size() >= 3) begin
        chk("rpt_first", rt[1] - rt[0], RD);
        chk("rpt_next", rt[2] - rt[1], RP);
      end
      clr_counts();
      inp[2] = 1'b0;
      steps(40);
      chk("rpt_fall", fall_cnt[2], 1);
      chk("rpt_stop", rise_cnt[2], 0);
    end

    // random toggling with one asynchronous reset
    for (int k = 0; k < 800; k++) begin
      for (int i = 0; i < CH; i++)
        if ($urandom_range(0, 7) == 0) inp[i] = ~inp[i];
      if (k == 400) do_reset();
      else step();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/multi_button_debouncer.md
Name: multi_button_debouncer

Overview:
- Parametrised N-channel debouncer for the board's push-buttons and switches; sits between raw pad inputs and the VGA control logic.
- Fully synchronous to clk: a tick-enable replaces any derived sampling clock.
- Per channel: 2-flop synchroniser, SAMPLES-deep sample history, hysteresis state, and one-cycle press/release pulses.

Parameters:
- CHANNELS, 4, number of independent button inputs (>=1).
- TICK_DIV, 262144, clk cycles per sample tick (>=2); counter width is $clog2(TICK_DIV).
- SAMPLES, 3, consecutive equal samples required to change state (2..16).
- REPEAT_DELAY, 50, ticks held before auto-repeat starts (optional feature only).
- REPEAT_PERIOD, 10, ticks between auto-repeat pulses (optional feature only).

Ports:
- clk  in  1  system clock.
- clr  in  1  asynchronous active-high reset.
- inp  in  CHANNELS  raw asynchronous button levels.
- outp  out  CHANNELS  debounced level per channel.
- rise  out  CHANNELS  one-clk pulse on debounced 0->1 (press).
- fall  out  CHANNELS  one-clk pulse on debounced 1->0 (release).
- tick  out  1  sample-tick strobe, exported for reuse.

Behaviour:
- Reset: clr is asynchronous and active-high. While clr=1, all flops clear: divider=0, tick=0, synchronisers=0, histories=0, outp=0, rise=0, fall=0, repeat counters=0. Release is taken synchronously at the next clk edge.
- Divider: counts 0..TICK_DIV-1 and wraps to 0. tick=1 for exactly one clk in the cycle where count==TICK_DIV-1; the first tick occurs TICK_DIV cycles after reset release.
- Synchroniser: inp[i] passes through 2 flops to give s[i]; the 2-cycle latency is unconditional.
- Sampling: only on cycles where tick=1, hist[i] shifts left and takes s[i]; hist is SAMPLES bits wide.
- State update, on the same tick edge:
  - if hist after the shift is all-ones, outp goes to 1;
  - if it is all-zeros, outp goes to 0;
  - otherwise outp holds (hysteresis; a single sample of the opposite level never clears outp).
- Pulses: rise[i] is registered and equals 1 exactly in the clk cycle following the edge where outp[i] goes 0->1; fall[i] likewise for 1->0. Pulse width is exactly 1 clk. rise and fall are never both 1 on the same channel.
- Worst-case press latency: 2 + SAMPLES*TICK_DIV clk from a stable input change.
- Channels are fully independent; simultaneous transitions on several channels produce simultaneous pulses.
- Glitch shorter than one tick period: at most one sample differs, so outp is unchanged (requires SAMPLES>=2).
- clr asserted mid-count or mid-press: everything clears immediately and no pulse is emitted; after release, a held button needs the full SAMPLES ticks again before rise fires.
- No wrap issue on hist; the divider wrap is the only counter wrap.

Optional Feature:
- Macro: MULTI_BUTTON_DEBOUNCER_REPEAT_EN.
- Defined: each channel has a tick counter that runs while outp[i]=1 and clears to 0 when outp[i]=0. When it reaches REPEAT_DELAY, rise[i] pulses again for 1 clk and the counter reloads to REPEAT_DELAY-REPEAT_PERIOD. Net effect: repeats every REPEAT_PERIOD ticks while the button is held. fall is unaffected.
- Undefined: no repeat counters are built; rise fires once per press; the REPEAT_* parameters are ignored.

Decomposition:
- Package multi_button_debouncer_pkg holds:
  - localparam helper for divider width, $clog2(TICK_DIV);
  - default constants TICK_DIV_DEFAULT=262144 and SAMPLES_DEFAULT=3;
  - repeat counter width, $clog2(REPEAT_DELAY+1).
- Sub-module debounce_channel (synchroniser, history, state, pulse, optional repeat) is instantiated CHANNELS times via generate. The divider and tick stay in the top level.

Test Plan (bench parameters TICK_DIV=4, SAMPLES=3, CHANNELS=4):
- Reset: hold clr with inp=4'hF -> outp=0, rise=0, fall=0, tick=0. After release, tick first seen high 4 cycles later, then every 4th cycle.
- Clean press: inp[0]=1 held -> outp[0]=1 within 2+12 clk, rise[0] high exactly 1 clk, other channels stay 0. Release -> fall[0] 1 clk, outp[0]=0.
- Glitch: inp[1] high for 3 clk spanning one tick -> outp[1] stays 0, no rise. Then with outp[1]=1, a 3-clk low -> outp[1] stays 1, no fall.
- Simultaneous: inp=4'b1010 at once -> rise=4'b1010 in the same cycle.
- Mid-press reset: assert clr after 2 of 3 good samples -> all outputs 0 at once. After release with input still high, rise arrives only after 3 further ticks.
- With MULTI_BUTTON_DEBOUNCER_REPEAT_EN, REPEAT_DELAY=5, REPEAT_PERIOD=2: hold inp[2] -> initial rise, second rise 5 ticks later, then every 2 ticks. Release -> fall once, repeats stop.
